// File: rtl/dmem_arb_pkg.sv
// Shared types, funct3 encodings and the access legality rule for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
  typedef enum logic {REQ_CORE = 1'b0, REQ_DMA = 1'b1} req_id_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Stores only have signed-form widths; unsigned forms are load-only.
  function automatic logic legal_access(input logic we, input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (funct3)
      F3_B:  ok = 1'b1;
      F3_BU: ok = !we;
      F3_H:  ok = !addr_lo[0];
      F3_HU: ok = !we && !addr_lo[0];
      F3_W:  ok = (addr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_rr_picker.sv
// Two-way round-robin pick: on a tie the port not granted last wins.
module dmem_rr_picker (
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner,
  output logic       any
);

  always_comb begin
    any    = |req;
    winner = (&req) ? ~last : req[1];
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates core and DMA masters onto one data-memory port, one access at a time,
// rejecting illegal or misaligned requests before they reach memory.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  c_req,
  input  logic                  c_we,
  input  logic [DM_ADDRESS-1:0] c_addr,
  input  logic [DATA_W-1:0]     c_wdata,
  input  logic [2:0]            c_funct3,
  output logic                  c_gnt,
  output logic                  c_rvalid,
  output logic [DATA_W-1:0]     c_rdata,
  output logic                  c_err,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DM_ADDRESS-1:0] d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [2:0]            d_funct3,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_err,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic [DM_ADDRESS-1:0] a,
  output logic [DATA_W-1:0]     wd,
  output logic [2:0]            Funct3,
  input  logic [DATA_W-1:0]     rd
);

  state_t                r_state, w_next;
  logic                  r_last;
  logic                  r_we;
  logic [DM_ADDRESS-1:0] r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [2:0]            r_f3;
  req_id_t               r_id;
  logic [DATA_W-1:0]     r_c_rdata, r_d_rdata;
  logic                  w_any, w_winner, w_legal;

  dmem_rr_picker u_pick (
    .req    ({d_req, c_req}),
    .last   (r_last),
    .winner (w_winner),
    .any    (w_any)
  );

  assign w_legal = legal_access(r_we, r_f3, r_addr[1:0]);
  assign c_rdata = r_c_rdata;
  assign d_rdata = r_d_rdata;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = ACCESS;
      ACCESS:  w_next = (w_legal && !r_we) ? RESP : IDLE;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    c_gnt    = 1'b0;
    d_gnt    = 1'b0;
    c_err    = 1'b0;
    d_err    = 1'b0;
    c_rvalid = 1'b0;
    d_rvalid = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    a        = '0;
    wd       = '0;
    Funct3   = '0;
    case (r_state)
      ACCESS: begin
        if (w_legal) begin
          MemRead  = !r_we;
          MemWrite = r_we;
          a        = r_addr;
          wd       = r_wdata;
          Funct3   = r_f3;
          c_gnt    = (r_id == REQ_CORE);
          d_gnt    = (r_id == REQ_DMA);
        end else begin
          c_err    = (r_id == REQ_CORE);
          d_err    = (r_id == REQ_DMA);
        end
      end
      RESP: begin
        c_rvalid = (r_id == REQ_CORE);
        d_rvalid = (r_id == REQ_DMA);
      end
      default: ;
    endcase
  end

  // Request latch, fairness pointer and per-port load result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last    <= 1'b1;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_f3      <= '0;
      r_id      <= REQ_CORE;
      r_c_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      if (r_state == IDLE && w_any) begin
        r_id    <= w_winner ? REQ_DMA : REQ_CORE;
        r_we    <= w_winner ? d_we     : c_we;
        r_addr  <= w_winner ? d_addr   : c_addr;
        r_wdata <= w_winner ? d_wdata  : c_wdata;
        r_f3    <= w_winner ? d_funct3 : c_funct3;
      end
      if (r_state == ACCESS) begin
        r_last <= (r_id == REQ_DMA);
        if (w_legal && !r_we) begin
          if (r_id == REQ_CORE) r_c_rdata <= rd;
          else                  r_d_rdata <= rd;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed-vector bench for dmem_arbiter with hand-computed expectations.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        c_req, c_we, d_req, d_we;
  logic [8:0]  c_addr, d_addr;
  logic [31:0] c_wdata, d_wdata;
  logic [2:0]  c_funct3, d_funct3;
  logic        c_gnt, c_rvalid, c_err, d_gnt, d_rvalid, d_err;
  logic [31:0] c_rdata, d_rdata;
  logic        MemRead, MemWrite;
  logic [8:0]  a;
  logic [31:0] wd, rd;
  logic [2:0]  Funct3;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int c_rv_cyc, d_rv_cyc;

  dmem_arbiter #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_funct3(c_funct3),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .MemRead(MemRead), .MemWrite(MemWrite), .a(a), .wd(wd), .Funct3(Funct3), .rd(rd)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Everything the memory and both masters see, packed for one-shot "all quiet" checks.
  function automatic logic [31:0] strobes();
    return {24'd0, c_gnt, c_rvalid, c_err, d_gnt, d_rvalid, d_err, MemRead, MemWrite};
  endfunction

  task automatic do_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0; c_funct3 = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_funct3 = 0;
    rd = 0;
    do_reset();
    chk("reset_strobes", strobes(), 32'h0);
    chk("reset_a_wd", {a, wd[22:0]}, 32'h0);
    chk("reset_rdata", c_rdata | d_rdata, 32'h0);

    // Core LW alone
    c_req = 1; c_we = 0; c_addr = 9'h010; c_funct3 = 3'b010; rd = 32'hDEADBEEF;
    tick();
    chk("lw_gnt_strobes", strobes(), 32'h0000_0082);
    chk("lw_a", a, 32'h010);
    chk("lw_funct3", Funct3, 32'h2);
    c_req = 0;
    tick();
    chk("lw_rvalid", strobes(), 32'h0000_0040);
    chk("lw_rdata", c_rdata, 32'hDEADBEEF);
    tick();

    // Simultaneous core SW and DMA SB from reset: core wins the first tie
    do_reset();
    c_req = 1; c_we = 1; c_addr = 9'h004; c_wdata = 32'h11223344; c_funct3 = 3'b010;
    d_req = 1; d_we = 1; d_addr = 9'h021; d_wdata = 32'h000000AB; d_funct3 = 3'b000;
    tick();
    chk("tie_core_gnt", strobes(), 32'h0000_0081);
    chk("tie_core_f3", Funct3, 32'h2);
    chk("tie_core_wd", wd, 32'h11223344);
    c_req = 0;
    tick();
    chk("tie_idle_quiet", strobes(), 32'h0);
    tick();
    chk("tie_dma_gnt", strobes(), 32'h0000_0011);
    chk("tie_dma_a", a, 32'h021);
    chk("tie_dma_f3", Funct3, 32'h0);
    chk("tie_dma_wd", wd, 32'h000000AB);
    d_req = 0;
    tick();

    // Both hold requests: grants alternate c,d,c,d,c,d
    c_req = 1; d_req = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("rr_gnt%0d", i), {30'd0, c_gnt, d_gnt}, (i % 2 == 0) ? 32'h2 : 32'h1);
      tick();
    end
    c_req = 0; d_req = 0;

    // Misaligned core LH, then illegal store funct3=100 from DMA
    c_req = 1; c_we = 0; c_addr = 9'h003; c_funct3 = 3'b001;
    tick();
    chk("lh_mis_err", strobes(), 32'h0000_0020);
    c_req = 0;
    tick();
    chk("lh_mis_after", strobes(), 32'h0);
    d_req = 1; d_we = 1; d_addr = 9'h000; d_funct3 = 3'b100;
    tick();
    chk("sbu_err", strobes(), 32'h0000_0004);
    d_req = 0;
    tick();

    // DMA LW interrupted by reset during ACCESS
    d_req = 1; d_we = 0; d_addr = 9'h008; d_funct3 = 3'b010; rd = 32'hCAFEF00D;
    tick();
    chk("rst_dma_gnt", strobes(), 32'h0000_0012);
    d_req = 0; reset = 1;
    tick();
    reset = 0;
    chk("rst_quiet", strobes(), 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    tick();
    chk("rst_no_rvalid", strobes(), 32'h0);
    c_req = 1; c_we = 0; c_addr = 9'h00C; c_funct3 = 3'b010; rd = 32'h12345678;
    tick();
    chk("post_rst_gnt", strobes(), 32'h0000_0082);
    c_req = 0;
    tick();
    chk("post_rst_rdata", c_rdata, 32'h12345678);
    tick();

    // Core LBU then DMA LW back-to-back
    c_req = 1; c_we = 0; c_addr = 9'h005; c_funct3 = 3'b100; rd = 32'h000000A5;
    tick();
    chk("lbu_gnt", strobes(), 32'h0000_0082);
    chk("lbu_f3", Funct3, 32'h4);
    c_req = 0;
    d_req = 1; d_we = 0; d_addr = 9'h010; d_funct3 = 3'b010;
    tick();
    chk("lbu_rvalid", strobes(), 32'h0000_0040);
    c_rv_cyc = cyc;
    tick();
    tick();
    chk("b2b_dma_gnt", strobes(), 32'h0000_0012);
    rd = 32'h55AA55AA;
    d_req = 0;
    tick();
    chk("b2b_dma_rvalid", strobes(), 32'h0000_0008);
    d_rv_cyc = cyc;
    chk("b2b_d_rdata", d_rdata, 32'h55AA55AA);
    chk("b2b_c_rdata_kept", c_rdata, 32'h000000A5);
    chk("b2b_spacing", d_rv_cyc - c_rv_cyc, 32'd3);
    tick();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
